// File: rtl/mdu_ctrl.sv
// HI/LO multiply-divide sequencer for the EX stage: runs MULT/MULTU/DIV/DIVU against
// external units and owns the HI/LO registers. Define MDU_FLUSH_EN to add the flush port.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// S_IDLE     | accepting ops; MTHI/MTLO complete here in one cycle
// S_MUL_WAIT | multiplier busy, counter runs down to the result cycle
// S_DIV_WAIT | div_start held until div_ready
// S_DONE     | single non-stalled cycle that lets the op retire

module mdu_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
`ifdef MDU_FLUSH_EN
    input  logic        flush,
`endif
    input  logic [2:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        stallreq,
    output logic [31:0] hi_rdata,
    output logic [31:0] lo_rdata,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic        div_annul,
    output logic [31:0] div_opdata1,
    output logic [31:0] div_opdata2,
    input  logic        div_ready,
    input  logic [63:0] div_result
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [2:0] CNT_INIT = 3'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL_WAIT,
        S_DIV_WAIT,
        S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic [31:0] opa, opa_nxt;
    logic [31:0] opb, opb_nxt;
    logic        op_sgn, op_sgn_nxt;
    logic [31:0] hi, hi_nxt;
    logic [31:0] lo, lo_nxt;
    logic        flush_act;

`ifdef MDU_FLUSH_EN
    assign flush_act = flush;
`else
    assign flush_act = 1'b0;
`endif

    assign hi_rdata = hi;
    assign lo_rdata = lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            opa    <= '0;
            opb    <= '0;
            op_sgn <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            opa    <= opa_nxt;
            opb    <= opb_nxt;
            op_sgn <= op_sgn_nxt;
            hi     <= hi_nxt;
            lo     <= lo_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        opa_nxt     = opa;
        opb_nxt     = opb;
        op_sgn_nxt  = op_sgn;
        hi_nxt      = hi;
        lo_nxt      = lo;
        stallreq    = 1'b0;
        mul_signed  = 1'b0;
        mul_ina     = '0;
        mul_inb     = '0;
        div_start   = 1'b0;
        div_signed  = 1'b0;
        div_annul   = 1'b0;
        div_opdata1 = '0;
        div_opdata2 = '0;

        case (state)
            S_IDLE: begin
                // a flushed EX stage must not start or commit anything
                if (!flush_act) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            opa_nxt    = src1;
                            opb_nxt    = src2;
                            op_sgn_nxt = (op == OP_MULT);
                            cnt_nxt    = CNT_INIT;
                            stallreq   = 1'b1;
                            state_nxt  = S_MUL_WAIT;
                        end
                        OP_DIV, OP_DIVU: begin
                            stallreq = 1'b1;
                            if (src2 != '0) begin
                                opa_nxt    = src1;
                                opb_nxt    = src2;
                                op_sgn_nxt = (op == OP_DIV);
                                state_nxt  = S_DIV_WAIT;
                            end else begin
                                hi_nxt    = src1;
                                lo_nxt    = 32'hFFFF_FFFF;
                                state_nxt = S_DONE;
                            end
                        end
                        OP_MTHI: hi_nxt = src1;
                        OP_MTLO: lo_nxt = src1;
                        default: ;
                    endcase
                end
            end

            S_MUL_WAIT: begin
                mul_signed = op_sgn;
                mul_ina    = opa;
                mul_inb    = opb;
                if (flush_act) begin
                    state_nxt = S_IDLE;
                end else begin
                    stallreq = 1'b1;
                    if (cnt == '0) begin
                        hi_nxt    = mul_result[63:32];
                        lo_nxt    = mul_result[31:0];
                        state_nxt = S_DONE;
                    end else begin
                        cnt_nxt = cnt - 3'd1;
                    end
                end
            end

            S_DIV_WAIT: begin
                div_signed  = op_sgn;
                div_opdata1 = opa;
                div_opdata2 = opb;
                if (flush_act) begin
                    div_annul = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    // start stays high through the ready cycle; it drops when DONE is entered
                    stallreq  = 1'b1;
                    div_start = 1'b1;
                    if (div_ready) begin
                        hi_nxt    = div_result[63:32];
                        lo_nxt    = div_result[31:0];
                        state_nxt = S_DONE;
                    end
                end
            end

            S_DONE: state_nxt = S_IDLE;

            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
